// File: rtl/axil_ram_slave_if.sv
// axil_ram_slave_if: AXI4-Lite bus bundle between an interconnect master and the RAM slave
interface axil_ram_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    s_axi_awvalid;
    logic                    s_axi_awready;
    logic [ADDR_WIDTH-1:0]   s_axi_awaddr;
    logic [2:0]              s_axi_awprot;
    logic                    s_axi_wvalid;
    logic                    s_axi_wready;
    logic [DATA_WIDTH-1:0]   s_axi_wdata;
    logic [DATA_WIDTH/8-1:0] s_axi_wstrb;
    logic                    s_axi_bvalid;
    logic                    s_axi_bready;
    logic [1:0]              s_axi_bresp;
    logic                    s_axi_arvalid;
    logic                    s_axi_arready;
    logic [ADDR_WIDTH-1:0]   s_axi_araddr;
    logic [2:0]              s_axi_arprot;
    logic                    s_axi_rvalid;
    logic                    s_axi_rready;
    logic [DATA_WIDTH-1:0]   s_axi_rdata;
    logic [1:0]              s_axi_rresp;

    modport slave (
        input  s_axi_awvalid, s_axi_awaddr, s_axi_awprot,
        input  s_axi_wvalid, s_axi_wdata, s_axi_wstrb,
        input  s_axi_bready,
        input  s_axi_arvalid, s_axi_araddr, s_axi_arprot,
        input  s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
        output s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rresp
    );

    modport master (
        output s_axi_awvalid, s_axi_awaddr, s_axi_awprot,
        output s_axi_wvalid, s_axi_wdata, s_axi_wstrb,
        output s_axi_bready,
        output s_axi_arvalid, s_axi_araddr, s_axi_arprot,
        output s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
        input  s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rresp
    );
endinterface

// File: rtl/axil_ram_slave.sv
// axil_ram_slave: AXI4-Lite slave over an on-chip word RAM with byte strobes and range decode
module axil_ram_slave #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input logic              clk,
    input logic              rst,
    axil_ram_slave_if.slave  bus
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFS  = $clog2(BYTES);
    localparam int IW    = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH + 1)'(DEPTH_WORDS * BYTES);

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
        $error("axil_ram_slave: DATA_WIDTH must be 32 or 64");
    end

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t              w_state;
    r_state_t              r_state;
    logic                  aw_held;
    logic                  w_held;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [BYTES-1:0]      w_strb;
    logic                  commit;
    logic                  unused_ok;
    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    function automatic logic hit(input logic [ADDR_WIDTH-1:0] a);
        return a >= BASE_ADDR && {1'b0, a - BASE_ADDR} < SPAN;
    endfunction

    function automatic logic [IW-1:0] idx(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] o;
        o = a - BASE_ADDR;
        return o[OFFS +: IW];
    endfunction

    assign commit    = w_state == W_IDLE && aw_held && w_held;
    assign unused_ok = ^{bus.s_axi_awprot, bus.s_axi_arprot};

    // Write channel: capture AW and W independently, respond once both are held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state           <= W_IDLE;
            aw_held           <= 1'b0;
            w_held            <= 1'b0;
            aw_addr           <= '0;
            w_data            <= '0;
            w_strb            <= '0;
            bus.s_axi_awready <= 1'b0;
            bus.s_axi_wready  <= 1'b0;
            bus.s_axi_bvalid  <= 1'b0;
            bus.s_axi_bresp   <= 2'b00;
        end else if (w_state == W_IDLE) begin
            if (aw_held && w_held) begin
                w_state           <= W_RESP;
                bus.s_axi_awready <= 1'b0;
                bus.s_axi_wready  <= 1'b0;
                bus.s_axi_bvalid  <= 1'b1;
                bus.s_axi_bresp   <= hit(aw_addr) ? 2'b00 : 2'b10;
            end else begin
                if (bus.s_axi_awvalid && bus.s_axi_awready) begin
                    aw_held           <= 1'b1;
                    aw_addr           <= bus.s_axi_awaddr;
                    bus.s_axi_awready <= 1'b0;
                end else begin
                    bus.s_axi_awready <= !aw_held;
                end
                if (bus.s_axi_wvalid && bus.s_axi_wready) begin
                    w_held           <= 1'b1;
                    w_data           <= bus.s_axi_wdata;
                    w_strb           <= bus.s_axi_wstrb;
                    bus.s_axi_wready <= 1'b0;
                end else begin
                    bus.s_axi_wready <= !w_held;
                end
            end
        end else if (bus.s_axi_bready) begin
            w_state           <= W_IDLE;
            aw_held           <= 1'b0;
            w_held            <= 1'b0;
            bus.s_axi_bvalid  <= 1'b0;
            bus.s_axi_awready <= 1'b1;
            bus.s_axi_wready  <= 1'b1;
        end
    end

    // RAM write port: byte-masked commit of the held beat; contents survive reset
    always_ff @(posedge clk) begin
        if (commit && hit(aw_addr))
            for (int i = 0; i < BYTES; i++)
                if (w_strb[i]) mem[idx(aw_addr)][8*i +: 8] <= w_data[8*i +: 8];
    end

    // Read channel: register data on AR handshake and hold it until accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state           <= R_IDLE;
            bus.s_axi_arready <= 1'b0;
            bus.s_axi_rvalid  <= 1'b0;
            bus.s_axi_rdata   <= '0;
            bus.s_axi_rresp   <= 2'b00;
        end else if (r_state == R_IDLE) begin
            if (bus.s_axi_arvalid && bus.s_axi_arready) begin
                r_state           <= R_DATA;
                bus.s_axi_arready <= 1'b0;
                bus.s_axi_rvalid  <= 1'b1;
                bus.s_axi_rdata   <= hit(bus.s_axi_araddr) ? mem[idx(bus.s_axi_araddr)] : '0;
                bus.s_axi_rresp   <= hit(bus.s_axi_araddr) ? 2'b00 : 2'b10;
            end else begin
                bus.s_axi_arready <= 1'b1;
            end
        end else if (bus.s_axi_rready) begin
            r_state           <= R_IDLE;
            bus.s_axi_rvalid  <= 1'b0;
            bus.s_axi_arready <= 1'b1;
        end
    end
endmodule

// File: tb/tb_axil_ram_slave.sv
// tb_axil_ram_slave: directed checks of handshakes, strobes, decode, stalls, same-edge hazard and reset
module tb_axil_ram_slave;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    axil_ram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axil_ram_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(1024), .BASE_ADDR(32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
        int t = 0;
        bus.s_axi_awaddr = a; bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wdata = d; bus.s_axi_wstrb = st; bus.s_axi_wvalid = 1'b1;
        while (!(bus.s_axi_awready && bus.s_axi_wready) && t < 20) begin @(negedge clk); t++; end
        chk("aw_w_wait", 64'(t < 20), 64'd1);
        @(negedge clk);
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
    endtask

    task automatic send_aw(input logic [31:0] a);
        int t = 0;
        bus.s_axi_awaddr = a; bus.s_axi_awvalid = 1'b1;
        while (!bus.s_axi_awready && t < 20) begin @(negedge clk); t++; end
        chk("aw_wait", 64'(t < 20), 64'd1);
        @(negedge clk);
        bus.s_axi_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] st);
        int t = 0;
        bus.s_axi_wdata = d; bus.s_axi_wstrb = st; bus.s_axi_wvalid = 1'b1;
        while (!bus.s_axi_wready && t < 20) begin @(negedge clk); t++; end
        chk("w_wait", 64'(t < 20), 64'd1);
        @(negedge clk);
        bus.s_axi_wvalid = 1'b0;
    endtask

    task automatic take_b(input logic [1:0] resp);
        int t = 0;
        bus.s_axi_bready = 1'b1;
        while (!bus.s_axi_bvalid && t < 20) begin @(negedge clk); t++; end
        chk("b_wait", 64'(t < 20), 64'd1);
        chk("bresp", 64'(bus.s_axi_bresp), 64'(resp));
        @(negedge clk);
        bus.s_axi_bready = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a);
        int t = 0;
        bus.s_axi_araddr = a; bus.s_axi_arvalid = 1'b1;
        while (!bus.s_axi_arready && t < 20) begin @(negedge clk); t++; end
        chk("ar_wait", 64'(t < 20), 64'd1);
        @(negedge clk);
        bus.s_axi_arvalid = 1'b0;
    endtask

    task automatic take_r(input logic [31:0] d, input logic [1:0] resp);
        int t = 0;
        bus.s_axi_rready = 1'b1;
        while (!bus.s_axi_rvalid && t < 20) begin @(negedge clk); t++; end
        chk("r_wait", 64'(t < 20), 64'd1);
        chk("rdata", 64'(bus.s_axi_rdata), 64'(d));
        chk("rresp", 64'(bus.s_axi_rresp), 64'(resp));
        @(negedge clk);
        bus.s_axi_rready = 1'b0;
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st, input logic [1:0] resp);
        send_aw_w(a, d, st);
        take_b(resp);
    endtask

    task automatic read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
        send_ar(a);
        take_r(d, resp);
    endtask

    initial begin
        bus.s_axi_awvalid = 1'b0; bus.s_axi_awaddr = '0; bus.s_axi_awprot = '0;
        bus.s_axi_wvalid = 1'b0; bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0;
        bus.s_axi_bready = 1'b0;
        bus.s_axi_arvalid = 1'b0; bus.s_axi_araddr = '0; bus.s_axi_arprot = '0;
        bus.s_axi_rready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_awready", 64'(bus.s_axi_awready), 64'd0);
        chk("rst_wready", 64'(bus.s_axi_wready), 64'd0);
        chk("rst_arready", 64'(bus.s_axi_arready), 64'd0);
        chk("rst_bvalid", 64'(bus.s_axi_bvalid), 64'd0);
        chk("rst_rvalid", 64'(bus.s_axi_rvalid), 64'd0);
        chk("rst_bresp", 64'(bus.s_axi_bresp), 64'd0);
        chk("rst_rresp", 64'(bus.s_axi_rresp), 64'd0);
        chk("rst_rdata", 64'(bus.s_axi_rdata), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        send_aw_w(32'h10, 32'hDEADBEEF, 4'hF);
        chk("b_latency_early", 64'(bus.s_axi_bvalid), 64'd0);
        @(negedge clk);
        chk("b_latency", 64'(bus.s_axi_bvalid), 64'd1);
        chk("b_latency_resp", 64'(bus.s_axi_bresp), 64'd0);
        bus.s_axi_bready = 1'b1;
        @(negedge clk);
        bus.s_axi_bready = 1'b0;
        chk("b_drop", 64'(bus.s_axi_bvalid), 64'd0);
        chk("aw_reopen", 64'(bus.s_axi_awready), 64'd1);
        read(32'h10, 32'hDEADBEEF, 2'b00);
        send_w(32'hAAAA5555, 4'h3);
        repeat (2) @(negedge clk);
        chk("w_held_ready", 64'(bus.s_axi_wready), 64'd0);
        chk("w_held_bvalid", 64'(bus.s_axi_bvalid), 64'd0);
        send_aw(32'h10);
        take_b(2'b00);
        read(32'h10, 32'hDEAD5555, 2'b00);
        write(32'h10, 32'hFFFFFFFF, 4'h0, 2'b00);
        read(32'h10, 32'hDEAD5555, 2'b00);
        write(32'h0, 32'h11111111, 4'hF, 2'b00);
        write(32'hFFC, 32'hCAFEF00D, 4'hF, 2'b00);
        write(32'h1000, 32'h12345678, 4'hF, 2'b10);
        read(32'h1000, 32'h0, 2'b10);
        read(32'hFFC, 32'hCAFEF00D, 2'b00);
        read(32'h0, 32'h11111111, 2'b00);
        send_aw_w(32'h30, 32'h5A5A5A5A, 4'hF);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("stall_bvalid", 64'(bus.s_axi_bvalid), 64'd1);
            chk("stall_bresp", 64'(bus.s_axi_bresp), 64'd0);
            chk("stall_awready", 64'(bus.s_axi_awready), 64'd0);
            chk("stall_wready", 64'(bus.s_axi_wready), 64'd0);
            @(negedge clk);
        end
        take_b(2'b00);
        send_ar(32'h30);
        for (int i = 0; i < 5; i++) begin
            chk("stall_rvalid", 64'(bus.s_axi_rvalid), 64'd1);
            chk("stall_rdata", 64'(bus.s_axi_rdata), 64'h5A5A5A5A);
            chk("stall_rresp", 64'(bus.s_axi_rresp), 64'd0);
            chk("stall_arready", 64'(bus.s_axi_arready), 64'd0);
            @(negedge clk);
        end
        take_r(32'h5A5A5A5A, 2'b00);
        chk("ar_reopen", 64'(bus.s_axi_arready), 64'd1);
        write(32'h20, 32'h0, 4'hF, 2'b00);
        chk("hz_aw_ready", 64'(bus.s_axi_awready && bus.s_axi_wready), 64'd1);
        bus.s_axi_awaddr = 32'h20; bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wdata = 32'h1; bus.s_axi_wstrb = 4'hF; bus.s_axi_wvalid = 1'b1;
        @(negedge clk);
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
        chk("hz_ar_ready", 64'(bus.s_axi_arready), 64'd1);
        bus.s_axi_araddr = 32'h20; bus.s_axi_arvalid = 1'b1;
        @(negedge clk);
        bus.s_axi_arvalid = 1'b0;
        chk("hz_rvalid", 64'(bus.s_axi_rvalid), 64'd1);
        chk("hz_bvalid", 64'(bus.s_axi_bvalid), 64'd1);
        take_b(2'b00);
        take_r(32'h0, 2'b00);
        read(32'h20, 32'h1, 2'b00);
        write(32'h40, 32'h77, 4'hF, 2'b00);
        send_aw(32'h40);
        bus.s_axi_wdata = 32'h99; bus.s_axi_wstrb = 4'hF; bus.s_axi_wvalid = 1'b1;
        rst = 1'b1;
        #1;
        chk("mid_rst_awready", 64'(bus.s_axi_awready), 64'd0);
        chk("mid_rst_wready", 64'(bus.s_axi_wready), 64'd0);
        chk("mid_rst_arready", 64'(bus.s_axi_arready), 64'd0);
        chk("mid_rst_bvalid", 64'(bus.s_axi_bvalid), 64'd0);
        chk("mid_rst_rvalid", 64'(bus.s_axi_rvalid), 64'd0);
        chk("mid_rst_rdata", 64'(bus.s_axi_rdata), 64'd0);
        @(negedge clk);
        bus.s_axi_wvalid = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_bvalid", 64'(bus.s_axi_bvalid), 64'd0);
        read(32'h40, 32'h77, 2'b00);
        read(32'h10, 32'hDEAD5555, 2'b00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
